// File: rtl/pc_sequencer.sv
// PC sequencer: presents fetch addresses, selects redirects (jr > jump > branch), buffers a redirect across fetch stalls.
// Optional macro PC_ALIGN_CHECK_EN steers misaligned jr targets to EXC_VECTOR.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        fetch_ready_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_offset_i,
    input  logic        jump_i,
    input  logic [25:0] jump_index_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
    output logic [31:0] pc_o,
    output logic        pc_valid_o,
    output logic        pc_flush_o,
    output logic        redirect_pending_o
);

    // state | meaning
    // BOOT  | first cycle after reset, pc not yet presented
    // RUN   | presenting pc, redirects acted on directly
    // HOLD  | redirect buffered while fetch stalls
    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_tgt;
    logic [31:0] jump_tgt;
    logic [31:0] jr_tgt;
    logic [31:0] redir_tgt;
    logic        redirect;
    logic        handshake;

    assign pc_plus4 = pc_q + 32'd4;
    assign br_tgt   = pc_plus4 + {br_offset_i[29:0], 2'b00};
    assign jump_tgt = {pc_plus4[31:28], jump_index_i, 2'b00};

`ifdef PC_ALIGN_CHECK_EN
    assign jr_tgt = (jr_target_i[1:0] != 2'b00) ? EXC_VECTOR : jr_target_i;
`else
    assign jr_tgt = jr_target_i;
`endif

    assign redirect  = jr_i | jump_i | br_taken_i;
    assign redir_tgt = jr_i   ? jr_tgt   :
                       jump_i ? jump_tgt : br_tgt;

    assign pc_valid_o         = (state_q != BOOT);
    assign handshake          = pc_valid_o && fetch_ready_i;
    assign pc_flush_o         = (state_q == HOLD) && fetch_ready_i;
    assign redirect_pending_o = (state_q == HOLD);
    assign pc_o               = pc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (handshake) begin
                    pc_d = redirect ? redir_tgt : pc_plus4;
                end else if (redirect) begin
                    pend_d  = redir_tgt;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Later redirects are younger than the buffered one and are dropped.
                if (handshake) begin
                    pc_d    = pend_q;
                    pend_d  = 32'd0;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            pend_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: hand-computed expected pc/flag values after each clock.
module tb_pc_sequencer;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        fetch_ready_i;
    logic        br_taken_i;
    logic [31:0] br_offset_i;
    logic        jump_i;
    logic [25:0] jump_index_i;
    logic        jr_i;
    logic [31:0] jr_target_i;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        pc_flush_o;
    logic        redirect_pending_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    pc_sequencer dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .fetch_ready_i     (fetch_ready_i),
        .br_taken_i        (br_taken_i),
        .br_offset_i       (br_offset_i),
        .jump_i            (jump_i),
        .jump_index_i      (jump_index_i),
        .jr_i              (jr_i),
        .jr_target_i       (jr_target_i),
        .pc_o              (pc_o),
        .pc_valid_o        (pc_valid_o),
        .pc_flush_o        (pc_flush_o),
        .redirect_pending_o(redirect_pending_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        br_taken_i   = 1'b0;
        br_offset_i  = 32'd0;
        jump_i       = 1'b0;
        jump_index_i = 26'd0;
        jr_i         = 1'b0;
        jr_target_i  = 32'd0;
    endtask

    // Jump to an aligned address via jr with an accepting fetch stage.
    task automatic go_to(input logic [31:0] addr);
        fetch_ready_i = 1'b1;
        jr_i          = 1'b1;
        jr_target_i   = addr;
        step();
        idle_inputs();
        chk("go_to", pc_o, addr);
    endtask

    logic [31:0] exp_misalign;

    initial begin
`ifdef PC_ALIGN_CHECK_EN
        exp_misalign = 32'h8000_0180;
`else
        exp_misalign = 32'h0000_0402;
`endif
        reset_i       = 1'b1;
        fetch_ready_i = 1'b1;
        idle_inputs();
        step();
        step();
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_valid", {31'd0, pc_valid_o}, 32'd0);
        chk("rst_flush", {31'd0, pc_flush_o}, 32'd0);
        chk("rst_pend", {31'd0, redirect_pending_o}, 32'd0);

        // Boot sequence: one invalid cycle, then 0, 4, 8
        reset_i = 1'b0;
        #1;
        chk("boot_valid", {31'd0, pc_valid_o}, 32'd0);
        step();
        chk("run_valid", {31'd0, pc_valid_o}, 32'd1);
        chk("seq0", pc_o, 32'h0);
        step();
        chk("seq4", pc_o, 32'h4);
        step();
        chk("seq8", pc_o, 32'h8);

        // Backward branch
        go_to(32'h0000_1000);
        br_taken_i  = 1'b1;
        br_offset_i = 32'hFFFF_FFFE;
        step();
        idle_inputs();
        chk("branch_back", pc_o, 32'h0000_0FFC);

        // Jump beats branch
        go_to(32'h3000_0010);
        jump_i       = 1'b1;
        br_taken_i   = 1'b1;
        br_offset_i  = 32'h0000_0010;
        jump_index_i = 26'h000_0040;
        step();
        idle_inputs();
        chk("jump_over_br", pc_o, 32'h3000_0100);

        // jr beats jump
        jr_i         = 1'b1;
        jr_target_i  = 32'h0000_2000;
        jump_i       = 1'b1;
        jump_index_i = 26'h000_0123;
        step();
        idle_inputs();
        chk("jr_over_jump", pc_o, 32'h0000_2000);

        // Stall without redirect holds everything
        fetch_ready_i = 1'b0;
        step();
        chk("stall_pc", pc_o, 32'h0000_2000);
        chk("stall_pend", {31'd0, redirect_pending_o}, 32'd0);

        // Buffered redirect across a stall, later jump ignored
        go_to(32'h0000_0100);
        fetch_ready_i = 1'b0;
        jr_i          = 1'b1;
        jr_target_i   = 32'h0000_0400;
        step();
        idle_inputs();
        chk("hold_pc", pc_o, 32'h0000_0100);
        chk("hold_pend", {31'd0, redirect_pending_o}, 32'd1);
        jump_i       = 1'b1;
        jump_index_i = 26'h000_0777;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("hold_stall_pc", pc_o, 32'h0000_0100);
            chk("hold_stall_pend", {31'd0, redirect_pending_o}, 32'd1);
            chk("hold_stall_flush", {31'd0, pc_flush_o}, 32'd0);
        end
        fetch_ready_i = 1'b1;
        #1;
        chk("hold_flush", {31'd0, pc_flush_o}, 32'd1);
        step();
        idle_inputs();
        #1;
        chk("hold_release_pc", pc_o, 32'h0000_0400);
        chk("hold_release_pend", {31'd0, redirect_pending_o}, 32'd0);
        chk("run_flush", {31'd0, pc_flush_o}, 32'd0);

        // Wraparound of pc + 4
        go_to(32'hFFFF_FFFC);
        step();
        chk("wrap", pc_o, 32'h0);

        // Reset while holding discards the pending redirect
        fetch_ready_i = 1'b0;
        jr_i          = 1'b1;
        jr_target_i   = 32'h0000_0500;
        step();
        chk("pre_rst_pend", {31'd0, redirect_pending_o}, 32'd1);
        reset_i       = 1'b1;
        fetch_ready_i = 1'b1;
        step();
        idle_inputs();
        chk("hold_rst_pc", pc_o, 32'h0);
        chk("hold_rst_pend", {31'd0, redirect_pending_o}, 32'd0);
        chk("hold_rst_valid", {31'd0, pc_valid_o}, 32'd0);
        reset_i = 1'b0;
        step();
        chk("post_rst_pc", pc_o, 32'h0);
        step();
        chk("post_rst_seq", pc_o, 32'h4);

        // Misaligned jr, direct and buffered
        jr_i        = 1'b1;
        jr_target_i = 32'h0000_0402;
        step();
        idle_inputs();
        chk("jr_misalign", pc_o, exp_misalign);
        go_to(32'h0000_0200);
        fetch_ready_i = 1'b0;
        jr_i          = 1'b1;
        jr_target_i   = 32'h0000_0402;
        step();
        idle_inputs();
        fetch_ready_i = 1'b1;
        step();
        chk("jr_misalign_hold", pc_o, exp_misalign);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: PC loaded on reset.
REQ-002 Parameter EXC_VECTOR, default 32'h8000_0180: address-error target, used only with the REQ-026 macro.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 fetch_ready  input  1  fetch stage accepts pc this cycle.
REQ-006 br_taken  input  1  taken conditional branch from execute.
REQ-007 br_offset  input  32  sign-extended branch immediate, word units.
REQ-008 jump  input  1  J/JAL request.
REQ-009 jump_index  input  26  instr[25:0] of the jump.
REQ-010 jr  input  1  JR/JALR request.
REQ-011 jr_target  input  32  register-sourced target.
REQ-012 pc  output  32  current fetch address.
REQ-013 pc_valid  output  1  pc is presented to fetch.
REQ-014 pc_flush  output  1  the pc accepted this cycle is wrong-path; fetch discards it.
REQ-015 redirect_pending  output  1  buffered redirect waiting for handshake.

Function
REQ-016 Handshake: pc transfers when pc_valid && fetch_ready; pc is held stable while pc_valid && !fetch_ready.
REQ-017 pc_plus4 = pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-018 Targets: branch = pc_plus4 + (br_offset << 2), mod 2^32; jump = {pc_plus4[31:28], jump_index, 2'b00}; jr = jr_target.
REQ-019 Redirect priority when several requests are asserted: jr > jump > br_taken; sequential pc_plus4 otherwise.
REQ-020 FSM states BOOT, RUN, HOLD; reset enters BOOT; BOOT -> RUN after one cycle, with pc_valid=0 in BOOT and redirect inputs ignored.
REQ-021 RUN, handshake: pc <= selected target (redirect or pc_plus4) next cycle; stay in RUN.
REQ-022 RUN, no handshake, any redirect: latch target into pending register; pc unchanged; go to HOLD; redirect_pending=1 from the next cycle.
REQ-023 RUN, no handshake, no redirect: all state holds.
REQ-024 HOLD: redirect inputs ignored and the pending target is never overwritten; on handshake, pc_flush=1 in that cycle, pc <= pending target, and the FSM returns to RUN with redirect_pending=0.
REQ-025 pc_flush is combinational: 1 only in a HOLD handshake cycle.

Configuration
REQ-026 Macro PC_ALIGN_CHECK_EN: when defined, a selected jr redirect with jr_target[1:0] != 0 uses EXC_VECTOR as its target in place of jr_target, in RUN and when latched into HOLD.
REQ-027 When PC_ALIGN_CHECK_EN is undefined, jr_target is used unmodified.

Reset
REQ-028 On reset: pc=RESET_VECTOR, state=BOOT, pc_valid=0, pc_flush=0, redirect_pending=0, pending register cleared.
REQ-029 Reset asserted in any state, including HOLD, discards any pending redirect and takes priority over every other input that cycle.

Verification
REQ-030 Reset release, fetch_ready=1, no redirects -> pc_valid=0 for one cycle, then pc=0x0, 0x4, 0x8 on successive cycles.
REQ-031 pc=0x0000_1000, br_taken=1, br_offset=32'hFFFF_FFFE, handshake -> next pc=0x0000_0FFC.
REQ-032 pc=0x3000_0010, jump=1, br_taken=1, jump_index=26'h000_0040, handshake -> next pc=0x3000_0100 (jump beats branch).
REQ-033 pc=0x100, fetch_ready=0, jr=1, jr_target=0x400, then 2 stall cycles with jump=1 -> pc held 0x100, redirect_pending=1; fetch_ready=1 -> pc_flush=1 that cycle; next pc=0x400, redirect_pending=0.
REQ-034 pc=0xFFFF_FFFC, handshake, no redirect -> next pc=0x0000_0000.
REQ-035 PC_ALIGN_CHECK_EN defined, jr=1, jr_target=0x402, handshake -> next pc=0x8000_0180; undefined -> next pc=0x402.
